// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Combinational ALU plus a radix-2 restoring
// divider for DIV/DIVU that is compiled in only when EX_DIV_EN is defined.
module ex_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush_i,
   input  logic [2:0]  ex_alusel,
   input  logic [7:0]  ex_aluop,
   input  logic [31:0] ex_reg1,
   input  logic [31:0] ex_reg2,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        stallreq_o
);

   localparam logic       RstEnable    = 1'b1;
   localparam logic       WriteDisable = 1'b0;

   localparam logic [2:0] EXE_RES_NOP        = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC      = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT      = 3'b010;
   localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;

   localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
   localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
   localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
   localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
   localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
   localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
   localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
   localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
   localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
   localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
   localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   logic signed [31:0] reg1_s;
   logic signed [31:0] reg2_s;
   logic        [4:0]  sh;
   logic        [31:0] logic_res;
   logic        [31:0] shift_res;
   logic        [31:0] arith_res;
   logic        [31:0] alu_res;

   assign reg1_s = ex_reg1;
   assign reg2_s = ex_reg2;
   assign sh     = ex_reg1[4:0];

   always_comb begin
      logic_res = '0;
      shift_res = '0;
      arith_res = '0;
      case (ex_aluop)
         EXE_OR_OP:   logic_res = ex_reg1 | ex_reg2;
         EXE_AND_OP:  logic_res = ex_reg1 & ex_reg2;
         EXE_XOR_OP:  logic_res = ex_reg1 ^ ex_reg2;
         EXE_NOR_OP:  logic_res = ~(ex_reg1 | ex_reg2);
         EXE_SLL_OP:  shift_res = ex_reg2 << sh;
         EXE_SRL_OP:  shift_res = ex_reg2 >> sh;
         EXE_SRA_OP:  shift_res = $unsigned(reg2_s >>> sh);
         EXE_ADDU_OP: arith_res = ex_reg1 + ex_reg2;
         EXE_SUBU_OP: arith_res = ex_reg1 - ex_reg2;
         EXE_SLT_OP:  arith_res = {31'b0, (reg1_s < reg2_s)};
         EXE_SLTU_OP: arith_res = {31'b0, (ex_reg1 < ex_reg2)};
         default:     ;
      endcase
   end

   always_comb begin
      case (ex_alusel)
         EXE_RES_LOGIC:      alu_res = logic_res;
         EXE_RES_SHIFT:      alu_res = shift_res;
         EXE_RES_ARITHMETIC: alu_res = arith_res;
         EXE_RES_NOP:        alu_res = '0;
         default:            alu_res = '0;
      endcase
   end

`ifdef EX_DIV_EN
   localparam logic [1:0] DIV_FREE   = 2'd0;
   localparam logic [1:0] DIV_BYZERO = 2'd1;
   localparam logic [1:0] DIV_ON     = 2'd2;
   localparam logic [1:0] DIV_END    = 2'd3;

   function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   logic        is_div;
   logic        is_signed;
   logic [1:0]  state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] remd_q, remd_d;
   logic        negq_q, negq_d;
   logic        negr_q, negr_d;
   logic [33:0] trial;
   logic        qbit;
   logic [31:0] step_rem;
   logic [31:0] step_quo;

   assign is_div    = (ex_aluop == EXE_DIV_OP) || (ex_aluop == EXE_DIVU_OP);
   assign is_signed = (ex_aluop == EXE_DIV_OP);

   // dvd_q shifts left each step: its top bit feeds the partial remainder and
   // the new quotient bit enters at the bottom, so it ends holding the quotient.
   assign trial    = {1'b0, rem_q, dvd_q[31]} - {2'b00, dvs_q};
   assign qbit     = ~trial[33];
   assign step_rem = qbit ? trial[31:0] : {rem_q[30:0], dvd_q[31]};
   assign step_quo = {dvd_q[30:0], qbit};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quot_d  = quot_q;
      remd_d  = remd_q;
      negq_d  = negq_q;
      negr_d  = negr_q;
      case (state_q)
         DIV_FREE: begin
            if (is_div && !flush_i) begin
               if (ex_reg2 == 32'd0) begin
                  state_d = DIV_BYZERO;
               end else begin
                  dvd_d   = magnitude(ex_reg1, is_signed);
                  dvs_d   = magnitude(ex_reg2, is_signed);
                  rem_d   = '0;
                  cnt_d   = '0;
                  negq_d  = is_signed && (ex_reg1[31] ^ ex_reg2[31]);
                  negr_d  = is_signed && ex_reg1[31];
                  state_d = DIV_ON;
               end
            end
         end
         DIV_BYZERO: begin
            quot_d  = '0;
            remd_d  = '0;
            state_d = DIV_END;
         end
         DIV_ON: begin
            rem_d = step_rem;
            dvd_d = step_quo;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               quot_d  = cond_neg(step_quo, negq_q);
               remd_d  = cond_neg(step_rem, negr_q);
               state_d = DIV_END;
            end
         end
         DIV_END: state_d = DIV_FREE;
         default: state_d = DIV_FREE;
      endcase
      if (flush_i) begin
         state_d = DIV_FREE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         state_q <= DIV_FREE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         quot_q  <= '0;
         remd_q  <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quot_q  <= quot_d;
         remd_q  <= remd_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
      end
   end
`else
   logic unused_div_inputs;
   assign unused_div_inputs = clk ^ flush_i;
`endif

   always_comb begin
      wd_o       = ex_wd;
      wreg_o     = ex_wreg;
      wdata_o    = alu_res;
      whilo_o    = 1'b0;
      hi_o       = '0;
      lo_o       = '0;
      stallreq_o = 1'b0;
`ifdef EX_DIV_EN
      if (is_div && !flush_i) begin
         stallreq_o = (state_q != DIV_END);
         if (state_q == DIV_END) begin
            whilo_o = 1'b1;
            hi_o    = remd_q;
            lo_o    = quot_q;
         end
      end
`endif
      if (rst == RstEnable) begin
         wd_o       = '0;
         wreg_o     = WriteDisable;
         wdata_o    = '0;
         whilo_o    = 1'b0;
         hi_o       = '0;
         lo_o       = '0;
         stallreq_o = 1'b0;
      end
   end

endmodule
